// File: rtl/booth_radix4_multiplier_if.sv
// Operand/result handshake bundle for booth_radix4_multiplier.
// The requester uses the master modport and the multiplier uses the slave modport.
interface booth_radix4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               is_signed;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] out;

    modport master (
        output start, in1, in2, is_signed,
        input  busy, done, out
    );

    modport slave (
        input  start, in1, in2, is_signed,
        output busy, done, out
    );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 (modified Booth) sequential multiplier, signed/unsigned, start/busy/done handshake.
// Optional early termination on uniform remaining multiplier bits: define EARLY_TERM_EN.
module booth_radix4_multiplier #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH / 2 + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    booth_radix4_multiplier_if.slave  bus
);

    localparam int XW = WIDTH + 2;
    localparam logic [CNT_W-1:0] ITER_S = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] ITER_U = CNT_W'(WIDTH / 2 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      m_q, m_d;
    logic [XW-1:0]      a_q, a_d;
    logic [XW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               done_q, done_d;

    logic [2:0]          trip;
    logic [XW-1:0]       addend;
    logic [XW-1:0]       sum;
    logic                cin;
    logic signed [2*XW:0] shifted;
    logic                early;
`ifdef EARLY_TERM_EN
    logic [CNT_W:0]         shamt;
    logic [XW-1:0]          rem_mask;
    logic [XW-1:0]          rem_bits;
    logic signed [2*XW-1:0] realigned;
`endif

    // Booth recoding of {Q1,Q0,Q-1}; negation is one's complement plus carry-in.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
        trip   = {q_q[1:0], qm1_q};
        case (trip)
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = {m_q[XW-2:0], 1'b0};
            3'b100: begin
                addend = ~{m_q[XW-2:0], 1'b0};
                cin    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = ~m_q;
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        sum     = a_q + addend + XW'(cin);
        shifted = $signed({sum, q_q, qm1_q}) >>> 2;

`ifdef EARLY_TERM_EN
        // Low 2*cnt bits of Q plus Q-1 are the triplets still to be decoded.
        shamt     = {cnt_q, 1'b0};
        rem_mask  = ~({XW{1'b1}} << shamt);
        rem_bits  = q_q & rem_mask;
        early     = ((rem_bits == '0) && !qm1_q) ||
                    (sgn_q && (rem_bits == rem_mask) && qm1_q);
        realigned = $signed({a_q, q_q}) >>> shamt;
`else
        early     = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    sgn_d   = bus.is_signed;
                    m_d     = bus.is_signed ? {{2{bus.in1[WIDTH-1]}}, bus.in1}
                                            : {2'b00, bus.in1};
                    q_d     = bus.is_signed ? {{2{bus.in2[WIDTH-1]}}, bus.in2}
                                            : {2'b00, bus.in2};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = bus.is_signed ? ITER_S : ITER_U;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (early) begin
`ifdef EARLY_TERM_EN
                    {a_d, q_d} = realigned;
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    {a_d, q_d, qm1_d} = shifted;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Signed mode ran one iteration fewer, so its product sits two bits higher.
                out_d   = sgn_q ? {a_q[WIDTH-1:0], q_q[XW-1:2]}
                                : {a_q[WIDTH-3:0], q_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule
